madd_msub_arbiter: RTL and testbench

//  Shares one serial modular add/sub unit (16-digit, count 0..15 per pass) among NREQ requesters.

---
 rtl/madd_msub_arbiter_pkg.sv | 25 ++
 rtl/madd_msub_arbiter_if.sv | 28 ++
 rtl/madd_msub_arbiter_rr_pick.sv | 31 +++
 rtl/madd_msub_arbiter.sv | 104 ++++++++++
 tb/tb_madd_msub_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/madd_msub_arbiter_pkg.sv
// Shared types and defaults for the modular add/sub unit arbiter.
package madd_msub_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_TIMEOUT = 40;
    localparam int DEFAULT_TO_W    = 6;

    // (a + b) mod n for operands already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/madd_msub_arbiter_if.sv
// Requester-side and unit-side signals of the arbiter; slave is the arbiter's view.
interface madd_msub_arbiter_if
    import madd_msub_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op_sub;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            flag;
    logic            err;
    logic            busy;
    logic            madd_en;
    logic            msub_en;
    logic            result_rdy;
    logic            result_flag;

    modport master (
        output req, op_sub, result_rdy, result_flag,
        input  gnt, done, flag, err, busy, madd_en, msub_en
    );

    modport slave (
        input  req, op_sub, result_rdy, result_flag,
        output gnt, done, flag, err, busy, madd_en, msub_en
    );
endinterface

// File: rtl/madd_msub_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module madd_msub_arbiter_rr_pick
    import madd_msub_arbiter_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that skips an assignment would infer a latch.
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(int'(ptr), k, NREQ);
            if (!valid && (((req >> cand) & NREQ'(1)) != '0)) begin
                valid  = 1'b1;
                idx    = IDX_W'(cand);
                onehot = NREQ'(1) << cand;
            end
        end
    end
endmodule

// File: rtl/madd_msub_arbiter.sv
// Shares one serial modular add/sub unit among NREQ requesters with a round-robin
// grant, one start pulse per grant and a watchdog that aborts a silent unit.
module madd_msub_arbiter
    import madd_msub_arbiter_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = DEFAULT_TO_W
) (
    input logic                clk,
    input logic                rst,
    madd_msub_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, ptr_q;
    logic [TO_W-1:0]  wd_q;
    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    op_t              pick_op;
    logic             wd_expired;

    madd_msub_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign pick_op    = ((bus.op_sub & pick_onehot) != '0) ? OP_SUB : OP_ADD;
    assign wd_expired = (wd_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.result_rdy || wd_expired) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered alongside the state, so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register here sample pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            wd_q        <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.flag    <= 1'b0;
            bus.err     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.madd_en <= 1'b0;
            bus.msub_en <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.done    <= '0;
            bus.err     <= 1'b0;
            bus.madd_en <= 1'b0;
            bus.msub_en <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        idx_q       <= pick_idx;
                        bus.gnt     <= pick_onehot;
                        bus.busy    <= 1'b1;
                        bus.madd_en <= (pick_op == OP_ADD);
                        bus.msub_en <= (pick_op == OP_SUB);
                    end
                end
                ST_ISSUE: wd_q <= '0;
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still counts as a normal completion.
                    if (bus.result_rdy) begin
                        bus.flag <= bus.result_flag;
                        bus.done <= bus.gnt;
                    end else if (wd_expired) begin
                        bus.flag <= 1'b0;
                        bus.err  <= 1'b1;
                        bus.done <= bus.gnt;
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr_q    <= IDX_W'(wrap_add(int'(idx_q), 1, NREQ));
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_madd_msub_arbiter.sv
// Directed bench for madd_msub_arbiter with a behavioural add/sub unit and an expectation queue.
module tb_madd_msub_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 40;
    localparam int TO_W    = 6;
    // ISSUE cycle = 0; unit rises 33 (17) edges after the start edge; done one cycle after WAIT samples it.
    localparam int LAT_ADD   = 35;
    localparam int LAT_SUB_S = 19;
    localparam int LAT_TO    = 1 + TIMEOUT;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            flag;
        logic            err;
        logic            sub;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int   cnt;
    logic model_hang;
    logic model_flag;
    logic sub_short;

    madd_msub_arbiter_if #(.NREQ(NREQ)) bus ();

    madd_msub_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Unit model: start clears result_rdy, which rises again after the op latency.
    always @(posedge clk) begin
        if (rst) begin
            bus.result_rdy  <= 1'b0;
            bus.result_flag <= 1'b0;
            cnt             <= 0;
        end else if (bus.madd_en || bus.msub_en) begin
            bus.result_rdy <= 1'b0;
            cnt <= model_hang ? 0 : ((bus.msub_en && sub_short) ? 17 : 33);
        end else if (cnt == 1) begin
            bus.result_rdy  <= 1'b1;
            bus.result_flag <= model_flag;
            cnt             <= 0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
            check("start_exclusive", 32'(bus.madd_en & bus.msub_en), 0);
            check("busy_vs_gnt", 32'(bus.busy), 32'(bus.gnt != '0));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_flag"}, 32'(bus.flag), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_madd_en"}, 32'(bus.madd_en), 0);
        check({tag, "_msub_en"}, 32'(bus.msub_en), 0);
    endtask

    // Follows one grant from the current negedge to its done pulse; returns on the DONE-cycle negedge.
    task automatic wait_op(input int exp_lat, input int exp_issue, input bit flip_op);
        exp_t e;
        int   t = 0, t_issue = -1, t_done = -1, n_add = 0, n_sub = 0;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        while (t_done < 0 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.madd_en) n_add++;
            if (bus.msub_en) n_sub++;
            if ((bus.madd_en || bus.msub_en) && t_issue < 0) begin
                t_issue = t;
                check("issue_gnt", 32'(bus.gnt), 32'(e.gnt));
                if (flip_op) bus.op_sub = ~bus.op_sub;
            end
            if (bus.done != '0) t_done = t;
        end
        check("done_seen", 32'(t_done >= 0), 1);
        if (exp_issue > 0) check("issue_latency", t_issue, exp_issue);
        check("done_latency", t_done - t_issue, exp_lat);
        check("done_vec", 32'(bus.done), 32'(e.gnt));
        check("done_gnt", 32'(bus.gnt), 32'(e.gnt));
        check("flag", 32'(bus.flag), 32'(e.flag));
        check("err", 32'(bus.err), 32'(e.err));
        check("madd_pulses", n_add, e.sub ? 0 : 1);
        check("msub_pulses", n_sub, e.sub ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t;
        rst        = 1'b1;
        bus.req    = '0;
        bus.op_sub = '0;
        model_hang = 1'b0;
        model_flag = 1'b1;
        sub_short  = 1'b0;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // 1: single add, op_sub flipped after grant must not matter
        @(negedge clk);
        bus.req = 4'b0001;
        sb.push_back('{4'b0001, 1'b1, 1'b0, 1'b0});
        wait_op(LAT_ADD, 1, 1'b1);
        bus.req    = '0;
        bus.op_sub = '0;
        repeat (3) @(negedge clk);
        check("idle_after_single", 32'(bus.busy), 0);

        // 2: fairness with all requesters held from reset
        rst     = 1'b1;
        bus.req = 4'b1111;
        sb.push_back('{4'b0001, 1'b1, 1'b0, 1'b0});
        sb.push_back('{4'b0010, 1'b1, 1'b0, 1'b0});
        sb.push_back('{4'b0100, 1'b1, 1'b0, 1'b0});
        sb.push_back('{4'b1000, 1'b1, 1'b0, 1'b0});
        sb.push_back('{4'b0001, 1'b1, 1'b0, 1'b0});
        do_reset();
        wait_op(LAT_ADD, 1, 1'b0);
        for (int i = 0; i < 4; i++) wait_op(LAT_ADD, 2, 1'b0);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // 3: short sub on requester 2
        model_flag = 1'b0;
        sub_short  = 1'b1;
        bus.req    = 4'b0100;
        bus.op_sub = 4'b0100;
        sb.push_back('{4'b0100, 1'b0, 1'b0, 1'b1});
        wait_op(LAT_SUB_S, 1, 1'b0);
        bus.req    = '0;
        bus.op_sub = '0;
        sub_short  = 1'b0;
        repeat (3) @(negedge clk);

        // 4: watchdog abort on requester 3, then pending requester 0 served
        model_hang = 1'b1;
        model_flag = 1'b1;
        bus.req    = 4'b1001;
        sb.push_back('{4'b1000, 1'b0, 1'b1, 1'b0});
        sb.push_back('{4'b0001, 1'b1, 1'b0, 1'b0});
        wait_op(LAT_TO, 1, 1'b0);
        model_hang = 1'b0;
        bus.req    = 4'b0001;
        wait_op(LAT_ADD, 2, 1'b0);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // 5: reset at WAIT cycle 10 abandons the grant; pointer restarts at 0
        bus.req = 4'b0001;
        t = 0;
        while (!bus.madd_en && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_issue", 32'(bus.madd_en), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pre_reset_no_done", 32'(bus.done), 0);
        end
        rst     = 1'b1;
        bus.req = 4'b0011;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        sb.push_back('{4'b0001, 1'b1, 1'b0, 1'b0});
        sb.push_back('{4'b0010, 1'b1, 1'b0, 1'b0});
        wait_op(LAT_ADD, 1, 1'b0);
        bus.req = 4'b0010;
        wait_op(LAT_ADD, 2, 1'b0);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // 6: stale result_rdy still high when the next grant starts
        check("stale_rdy_setup", 32'(bus.result_rdy), 1);
        model_flag = 1'b0;
        bus.req    = 4'b0010;
        sb.push_back('{4'b0010, 1'b0, 1'b0, 1'b0});
        wait_op(LAT_ADD, 1, 1'b0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
